// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared access-size codes and arbiter FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_RESP = 2'd1,
        D_RESP = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/riscv_mem_align_chk.sv
// ============================================================================
// Module      : riscv_mem_align_chk
// Description : Combinational natural-alignment check for a data access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_align_chk
    import riscv_mem_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [1:0] size,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr[0];
            SIZE_WORD: err = |addr;
            default:   err = 1'b1;  // size code 3 has no defined access
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Two-port (fetch/data) single-memory arbiter with fixed
//               priority, starvation relief and misalignment rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_PRIO  = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        ireq_i,
    input  logic [31:0] iaddr_i,
    output logic        igrant_o,
    output logic        irvalid_o,
    output logic [31:0] irdata_o,

    input  logic        dreq_i,
    input  logic        dwr_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [1:0]  dsize_i,
    output logic        dgrant_o,
    output logic        drvalid_o,
    output logic [31:0] drdata_o,
    output logic        derr_o,

    output logic [31:0] maddr_o,
    output logic [31:0] mwdata_o,
    output logic [1:0]  msize_o,
    output logic        mrd_o,
    output logic        mwr_o,
    input  logic [31:0] mrdata_i
);

    localparam int               c_CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);
    localparam logic             c_PREF_D     = (DATA_PRIO != 0);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [c_CNT_W-1:0] r_starve;
    logic [c_CNT_W-1:0] w_next_starve;
    logic               r_d_err;
    logic               r_d_wr;

    logic               w_both;
    logic               w_starved;
    logic               w_gnt_i;
    logic               w_gnt_d;
    logic               w_gnt_pref;
    logic               w_gnt_other;
    logic               w_misaligned;

    riscv_mem_align_chk u_align_chk (
        .addr (daddr_i[1:0]),
        .size (dsize_i),
        .err  (w_misaligned)
    );

    assign w_both    = ireq_i & dreq_i;
    assign w_starved = (r_starve == c_STARVE_LIM);

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (reset_i) begin
            if (w_both) begin
                if (c_PREF_D ^ w_starved) begin
                    w_gnt_d = 1'b1;
                end else begin
                    w_gnt_i = 1'b1;
                end
            end else begin
                w_gnt_i = ireq_i;
                w_gnt_d = dreq_i;
            end
        end
    end

    assign w_gnt_pref  = c_PREF_D ? w_gnt_d : w_gnt_i;
    assign w_gnt_other = c_PREF_D ? w_gnt_i : w_gnt_d;

    always_comb begin
        w_next_starve = r_starve;
        if (w_gnt_other) begin
            w_next_starve = '0;
        end else if (w_gnt_pref && w_both && !w_starved) begin
            w_next_starve = r_starve + c_CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_gnt_i) begin
            w_next_state = I_RESP;
        end else if (w_gnt_d) begin
            w_next_state = D_RESP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_d_err  <= 1'b0;
            r_d_wr   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_starve <= w_next_starve;
            if (w_gnt_d) begin
                r_d_err <= w_misaligned;
                r_d_wr  <= dwr_i;
            end
        end
    end

    // Memory request side: driven only in a granted cycle.
    always_comb begin
        maddr_o  = '0;
        mwdata_o = '0;
        msize_o  = SIZE_BYTE;
        mrd_o    = 1'b0;
        mwr_o    = 1'b0;
        if (w_gnt_i) begin
            maddr_o = iaddr_i;
            msize_o = SIZE_WORD;
            mrd_o   = 1'b1;
        end else if (w_gnt_d) begin
            maddr_o  = daddr_i;
            mwdata_o = dwdata_i;
            msize_o  = dsize_i;
            mrd_o    = !w_misaligned && !dwr_i;
            mwr_o    = !w_misaligned && dwr_i;
        end
    end

    assign igrant_o = w_gnt_i;
    assign dgrant_o = w_gnt_d;

    // A response still in flight when reset arrives is dropped.
    assign irvalid_o = reset_i && (r_state == I_RESP);
    assign drvalid_o = reset_i && (r_state == D_RESP);
    assign irdata_o  = irvalid_o ? mrdata_i : 32'd0;
    assign derr_o    = drvalid_o && r_d_err;
    assign drdata_o  = (drvalid_o && !r_d_err && !r_d_wr) ? mrdata_i : 32'd0;

endmodule

`default_nettype wire
